rtc_core: RTL and testbench
===========================

Name: rtc_core

Overview:
- Real-time clock datapath for the 1588 timer.
- Sits directly downstream of the register/CDC block and runs in the RTC clock domain.
- Consumes that block's one-cycle load/reset strobes and load data, and accumulates fractional-nanosecond time every clock.
- Feeds the running {seconds, nanoseconds} time back to the register block and to the RX/TX timestamp units.

Parameters:
- PERIOD_RST, 40'h0800000000, reset increment: {8b ns, 32b ns-fraction}; default is 8.0 ns, for 125 MHz.
- MODULO_RST, 38'h3B9ACA0000, reset ns rollover value: {30b ns, 8b ns-fraction}; default is 1e9 ns.

Ports:
- clk  in  1  RTC clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- rtc_rst_in  in  1  one-cycle strobe: clear time and any adjustment.
- time_ld_in  in  1  one-cycle strobe: load time.
- time_reg_ns_in  in  38  load value, {30b ns, 8b frac}.
- time_reg_sec_in  in  48  load value, seconds.
- period_ld_in  in  1  one-cycle strobe: capture period_in and time_acc_modulo_in.
- period_in  in  40  nominal increment, {8b ns, 32b frac}.
- time_acc_modulo_in  in  38  ns rollover value, {30b ns, 8b frac}.
- adj_ld_in  in  1  one-cycle strobe: start a timed adjustment.
- adj_ld_data_in  in  32  adjustment length in clk cycles.
- period_adj_in  in  40  increment used while an adjustment is active.
- time_reg_ns_out  out  38  current ns, {30b ns, 8b frac}; registered.
- time_reg_sec_out  out  48  current seconds; registered.
- adj_busy_out  out  1  high while the adjustment counter is non-zero.
- pps_out  out  1  one-cycle pulse on the cycle the seconds value increments.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All state changes on posedge clk.
- State:
  - acc: 62b = {30b ns, 32b frac}.
  - sec: 48b.
  - period_r: 40b.
  - modulo_r: 38b.
  - adj_cnt: 32b.
  - pps_r.
- Reset values:
  - acc = 0, sec = 0, adj_cnt = 0, pps_r = 0.
  - period_r = PERIOD_RST, modulo_r = MODULO_RST.
  - Outputs after reset: time_reg_ns_out = 0, time_reg_sec_out = 0, adj_busy_out = 0, pps_out = 0.
- Output mapping:
  - time_reg_ns_out = acc[61:24]; the lower 24 fraction bits are internal only.
  - time_reg_sec_out = sec.
  - adj_busy_out = (adj_cnt != 0).
  - pps_out = pps_r.
- Increment selection: inc = adj_cnt != 0 ? period_adj_in : period_r. period_adj_in is sampled live each cycle.
- Per-cycle tick:
  - sum = acc + zero-extended inc.
  - If sum >= {modulo_r, 24'd0}: acc <= sum - {modulo_r, 24'd0}, sec <= sec + 1 (48b wrap to 0), pps_r <= 1.
  - Otherwise: acc <= sum, pps_r <= 0.
  - At most one rollover per cycle. inc < modulo is a software precondition; it is not checked.
- Priority, highest first; one action per cycle for acc/sec:
  1. rst.
  2. rtc_rst_in: acc = 0, sec = 0, adj_cnt = 0, pps_r = 0. period_r and modulo_r are kept.
  3. time_ld_in: acc <= {time_reg_ns_in, 24'd0}, sec <= time_reg_sec_in, pps_r <= 0. No tick is applied that cycle.
  4. Normal tick.
- Load value above modulo: a time_ld ns value >= modulo_r is loaded as-is. The next tick subtracts modulo once.
- period_ld_in:
  - period_r <= period_in and modulo_r <= time_acc_modulo_in.
  - Independent of the time actions above.
  - The tick in the same cycle uses the old values; new values apply from the next cycle.
- adj_ld_in:
  - adj_cnt <= adj_ld_data_in, overriding any running count.
  - A value of 0 cancels an active adjustment.
  - The tick in the load cycle uses the pre-load adj_cnt.
- Adjustment countdown:
  - Otherwise, if adj_cnt != 0 and a tick occurs, adj_cnt decrements.
  - The cycle with rtc_rst_in clears it; a cycle with time_ld_in does not decrement it.
  - Load N with no interruption: exactly N subsequent ticks use period_adj_in, and adj_busy_out is high for exactly N cycles.
- Latency: every strobe is visible on the outputs 1 cycle after the strobe cycle.
- Simultaneous strobes: time_ld_in + adj_ld_in + period_ld_in in one cycle are all honoured. rtc_rst_in with adj_ld_in: rtc_rst_in wins for adj_cnt.

Test Plan:
- Reset, no loads -> with default 8.0 ns, time_reg_ns_out steps 0, 0x800, 0x1000, 0x1800 on successive cycles; sec = 0; adj_busy_out = 0.
- period_ld_in with period_in = 40'h0880000000 (8.5 ns), then time_ld_in with ns = 0, sec = 0 -> ns_out = 0, 0x880, 0x1100 (17.0 ns); the fraction carries correctly over 2 cycles.
- time_ld_in with ns = 38'h3B9AC9FC00 (999,999,996 ns), sec = 5, period 8 ns -> next cycle ns_out = 0x3B9ACA0400? no: the tick gives 1,000,000,004 ns, which rolls over -> ns_out = 0x400 (4 ns), sec = 6, pps_out = 1 for exactly one cycle.
- Period 8 ns, period_adj_in = 9 ns (40'h0900000000), adj_ld_in with data 3 at ns = 0 -> ns = 8 (load-cycle tick), then 17, 26, 35, then 43; adj_busy_out high for 3 cycles.
- adj_ld_in with data 100, then rtc_rst_in 10 cycles later -> next cycle ns = 0, sec = 0, adj_busy_out = 0; period_r still 8 ns, so the following cycle ns = 8.
- sec = 48'hFFFFFFFFFFFF with ns just below modulo -> rollover gives sec = 0, pps_out = 1.

Source files
------------

// File: rtl/rtc_core.sv
// 1588 real-time clock datapath: fractional-ns accumulator with seconds rollover,
// software time/period loads and a cycle-counted period adjustment.
module rtc_core #(
    parameter logic [39:0] PERIOD_RST = 40'h0800000000,
    parameter logic [37:0] MODULO_RST = 38'h3B9ACA0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rtc_rst_in,
    input  logic        time_ld_in,
    input  logic [37:0] time_reg_ns_in,
    input  logic [47:0] time_reg_sec_in,
    input  logic        period_ld_in,
    input  logic [39:0] period_in,
    input  logic [37:0] time_acc_modulo_in,
    input  logic        adj_ld_in,
    input  logic [31:0] adj_ld_data_in,
    input  logic [39:0] period_adj_in,
    output logic [37:0] time_reg_ns_out,
    output logic [47:0] time_reg_sec_out,
    output logic        adj_busy_out,
    output logic        pps_out
);

    logic [61:0] acc_q, acc_d;
    logic [47:0] sec_q, sec_d;
    logic [39:0] period_q, period_d;
    logic [37:0] modulo_q, modulo_d;
    logic [31:0] adj_cnt_q, adj_cnt_d;
    logic        pps_q, pps_d;
    logic        adj_busy_q, adj_busy_d;

    logic [39:0] inc_s;
    logic [62:0] sum_s;
    logic [61:0] limit_s;
    logic        roll_s;

    // Tick arithmetic; sum carries one spare bit so an over-modulo load cannot wrap.
    always_comb begin
        if (adj_cnt_q != 32'd0) begin
            inc_s = period_adj_in;
        end else begin
            inc_s = period_q;
        end
        sum_s   = {1'b0, acc_q} + {23'd0, inc_s};
        limit_s = {modulo_q, 24'd0};
        roll_s  = (sum_s >= {1'b0, limit_s});
    end

    // Next-state selection: clear, then load, then normal tick.
    always_comb begin
        acc_d     = acc_q;
        sec_d     = sec_q;
        pps_d     = 1'b0;
        adj_cnt_d = adj_cnt_q;
        period_d  = period_q;
        modulo_d  = modulo_q;

        if (rtc_rst_in) begin
            acc_d     = 62'd0;
            sec_d     = 48'd0;
            adj_cnt_d = 32'd0;
            pps_d     = 1'b0;
        end else if (time_ld_in) begin
            acc_d = {time_reg_ns_in, 24'd0};
            sec_d = time_reg_sec_in;
            pps_d = 1'b0;
            if (adj_ld_in) begin
                adj_cnt_d = adj_ld_data_in;
            end else begin
                adj_cnt_d = adj_cnt_q;
            end
        end else begin
            if (roll_s) begin
                acc_d = sum_s[61:0] - limit_s;
                sec_d = sec_q + 48'd1;
                pps_d = 1'b1;
            end else begin
                acc_d = sum_s[61:0];
                sec_d = sec_q;
                pps_d = 1'b0;
            end
            if (adj_ld_in) begin
                adj_cnt_d = adj_ld_data_in;
            end else if (adj_cnt_q != 32'd0) begin
                adj_cnt_d = adj_cnt_q - 32'd1;
            end else begin
                adj_cnt_d = adj_cnt_q;
            end
        end

        // Period/modulo capture is independent of the time actions.
        if (period_ld_in) begin
            period_d = period_in;
            modulo_d = time_acc_modulo_in;
        end else begin
            period_d = period_q;
            modulo_d = modulo_q;
        end

        adj_busy_d = (adj_cnt_d != 32'd0);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= 62'd0;
            sec_q      <= 48'd0;
            period_q   <= PERIOD_RST;
            modulo_q   <= MODULO_RST;
            adj_cnt_q  <= 32'd0;
            pps_q      <= 1'b0;
            adj_busy_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            sec_q      <= sec_d;
            period_q   <= period_d;
            modulo_q   <= modulo_d;
            adj_cnt_q  <= adj_cnt_d;
            pps_q      <= pps_d;
            adj_busy_q <= adj_busy_d;
        end
    end

    assign time_reg_ns_out  = acc_q[61:24];
    assign time_reg_sec_out = sec_q;
    assign adj_busy_out     = adj_busy_q;
    assign pps_out          = pps_q;

endmodule

// File: tb/tb_rtc_core.sv
// Self-checking bench for rtc_core: directed scenarios plus randomized strobes
// compared against a behavioural time model.
module tb_rtc_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        rtc_rst_in;
    logic        time_ld_in;
    logic [37:0] time_reg_ns_in;
    logic [47:0] time_reg_sec_in;
    logic        period_ld_in;
    logic [39:0] period_in;
    logic [37:0] time_acc_modulo_in;
    logic        adj_ld_in;
    logic [31:0] adj_ld_data_in;
    logic [39:0] period_adj_in;
    logic [37:0] time_reg_ns_out;
    logic [47:0] time_reg_sec_out;
    logic        adj_busy_out;
    logic        pps_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: time held as a count of 2^-32 ns units.
    logic [61:0] m_acc;
    logic [47:0] m_sec;
    logic [39:0] m_per;
    logic [37:0] m_mod;
    logic [31:0] m_adj;
    logic        m_pps;

    always #5 clk = ~clk;

    rtc_core dut (
        .clk(clk), .rst(rst),
        .rtc_rst_in(rtc_rst_in), .time_ld_in(time_ld_in),
        .time_reg_ns_in(time_reg_ns_in), .time_reg_sec_in(time_reg_sec_in),
        .period_ld_in(period_ld_in), .period_in(period_in),
        .time_acc_modulo_in(time_acc_modulo_in),
        .adj_ld_in(adj_ld_in), .adj_ld_data_in(adj_ld_data_in),
        .period_adj_in(period_adj_in),
        .time_reg_ns_out(time_reg_ns_out), .time_reg_sec_out(time_reg_sec_out),
        .adj_busy_out(adj_busy_out), .pps_out(pps_out)
    );

    task automatic model_update();
        logic [63:0] units;
        logic [63:0] one_sec;
        logic [63:0] rem;
        logic [39:0] step_units;
        if (rst) begin
            m_acc = 62'd0; m_sec = 48'd0; m_adj = 32'd0; m_pps = 1'b0;
            m_per = 40'h0800000000; m_mod = 38'h3B9ACA0000;
        end else begin
            step_units = (m_adj > 32'd0) ? period_adj_in : m_per;
            units   = 64'(m_acc) + 64'(step_units);
            one_sec = 64'(m_mod) * 64'd16777216;
            if (rtc_rst_in) begin
                m_acc = 62'd0; m_sec = 48'd0; m_adj = 32'd0; m_pps = 1'b0;
            end else if (time_ld_in) begin
                m_acc = 62'(64'(time_reg_ns_in) * 64'd16777216);
                m_sec = time_reg_sec_in;
                m_pps = 1'b0;
                if (adj_ld_in) m_adj = adj_ld_data_in;
            end else begin
                if (units >= one_sec) begin
                    rem   = units - one_sec;
                    m_acc = rem[61:0];
                    m_sec = m_sec + 48'd1;
                    m_pps = 1'b1;
                end else begin
                    m_acc = units[61:0];
                    m_pps = 1'b0;
                end
                if (adj_ld_in) m_adj = adj_ld_data_in;
                else if (m_adj > 32'd0) m_adj = m_adj - 32'd1;
            end
            if (period_ld_in) begin
                m_per = period_in;
                m_mod = time_acc_modulo_in;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        rtc_rst_in   = 1'b0;
        time_ld_in   = 1'b0;
        period_ld_in = 1'b0;
        adj_ld_in    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_checks++;
        if ({time_reg_ns_out, time_reg_sec_out, adj_busy_out, pps_out} !== {38'd0, 48'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got ns=%h sec=%h busy=%b pps=%b want all zero",
                     time_reg_ns_out, time_reg_sec_out, adj_busy_out, pps_out);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            n_checks++;
            if ({time_reg_ns_out, time_reg_sec_out, adj_busy_out} !== {38'(i * 32'h800), 48'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_count[%0d]: got ns=%h sec=%h busy=%b want ns=%h sec=0 busy=0",
                         i, time_reg_ns_out, time_reg_sec_out, adj_busy_out, 38'(i * 32'h800));
            end
        end
    endtask

    task automatic test_period();
        logic [37:0] want [3];
        want[0] = 38'h0; want[1] = 38'h880; want[2] = 38'h1100;
        period_ld_in = 1'b1; period_in = 40'h0880000000; time_acc_modulo_in = 38'h3B9ACA0000;
        step();
        time_ld_in = 1'b1; time_reg_ns_in = 38'd0; time_reg_sec_in = 48'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (time_reg_ns_out !== want[i]) begin
                n_fail++;
                $display("FAIL period_8p5[%0d]: got ns=%h want %h", i, time_reg_ns_out, want[i]);
            end
        end
        period_ld_in = 1'b1; period_in = 40'h0800000000;
        step();
    endtask

    task automatic test_rollover();
        time_ld_in = 1'b1; time_reg_ns_in = 38'h3B9AC9FC00; time_reg_sec_in = 48'd5;
        step();
        n_checks++;
        if ({time_reg_ns_out, time_reg_sec_out, pps_out} !== {38'h3B9AC9FC00, 48'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL rollover_load: got ns=%h sec=%h pps=%b want ns=3b9ac9fc00 sec=5 pps=0",
                     time_reg_ns_out, time_reg_sec_out, pps_out);
        end
        step();
        n_checks++;
        if ({time_reg_ns_out, time_reg_sec_out, pps_out} !== {38'h400, 48'd6, 1'b1}) begin
            n_fail++;
            $display("FAIL rollover_tick: got ns=%h sec=%h pps=%b want ns=400 sec=6 pps=1",
                     time_reg_ns_out, time_reg_sec_out, pps_out);
        end
        step();
        n_checks++;
        if ({time_reg_ns_out, time_reg_sec_out, pps_out} !== {38'hC00, 48'd6, 1'b0}) begin
            n_fail++;
            $display("FAIL rollover_after: got ns=%h sec=%h pps=%b want ns=c00 sec=6 pps=0",
                     time_reg_ns_out, time_reg_sec_out, pps_out);
        end
    endtask

    task automatic test_adjust();
        logic [37:0] want_ns [5];
        logic        want_busy [5];
        want_ns[0] = 38'h800;  want_busy[0] = 1'b1;
        want_ns[1] = 38'h1100; want_busy[1] = 1'b1;
        want_ns[2] = 38'h1A00; want_busy[2] = 1'b1;
        want_ns[3] = 38'h2300; want_busy[3] = 1'b0;
        want_ns[4] = 38'h2B00; want_busy[4] = 1'b0;
        time_ld_in = 1'b1; time_reg_ns_in = 38'd0; time_reg_sec_in = 48'd0;
        step();
        period_adj_in = 40'h0900000000;
        adj_ld_in = 1'b1; adj_ld_data_in = 32'd3;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({time_reg_ns_out, adj_busy_out} !== {want_ns[i], want_busy[i]}) begin
                n_fail++;
                $display("FAIL adjust[%0d]: got ns=%h busy=%b want ns=%h busy=%b",
                         i, time_reg_ns_out, adj_busy_out, want_ns[i], want_busy[i]);
            end
        end
    endtask

    task automatic test_rtc_rst();
        adj_ld_in = 1'b1; adj_ld_data_in = 32'd100;
        step();
        repeat (10) step();
        n_checks++;
        if (adj_busy_out !== 1'b1) begin
            n_fail++;
            $display("FAIL rtc_rst_busy_before: got busy=%b want 1", adj_busy_out);
        end
        rtc_rst_in = 1'b1;
        step();
        n_checks++;
        if ({time_reg_ns_out, time_reg_sec_out, adj_busy_out} !== {38'd0, 48'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL rtc_rst_clear: got ns=%h sec=%h busy=%b want 0/0/0",
                     time_reg_ns_out, time_reg_sec_out, adj_busy_out);
        end
        step();
        n_checks++;
        if ({time_reg_ns_out, adj_busy_out} !== {38'h800, 1'b0}) begin
            n_fail++;
            $display("FAIL rtc_rst_period_kept: got ns=%h busy=%b want ns=800 busy=0",
                     time_reg_ns_out, adj_busy_out);
        end
    endtask

    task automatic test_sec_wrap();
        time_ld_in = 1'b1; time_reg_ns_in = 38'h3B9AC9FC00; time_reg_sec_in = 48'hFFFFFFFFFFFF;
        step();
        step();
        n_checks++;
        if ({time_reg_ns_out, time_reg_sec_out, pps_out} !== {38'h400, 48'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL sec_wrap: got ns=%h sec=%h pps=%b want ns=400 sec=0 pps=1",
                     time_reg_ns_out, time_reg_sec_out, pps_out);
        end
    endtask

    task automatic test_load_above_modulo();
        time_ld_in = 1'b1; time_reg_ns_in = 38'h3B9ACA1000; time_reg_sec_in = 48'd20;
        step();
        n_checks++;
        if (time_reg_ns_out !== 38'h3B9ACA1000) begin
            n_fail++;
            $display("FAIL above_mod_load: got ns=%h want 3b9aca1000", time_reg_ns_out);
        end
        step();
        n_checks++;
        if ({time_reg_ns_out, time_reg_sec_out, pps_out} !== {38'h1800, 48'd21, 1'b1}) begin
            n_fail++;
            $display("FAIL above_mod_tick: got ns=%h sec=%h pps=%b want ns=1800 sec=21 pps=1",
                     time_reg_ns_out, time_reg_sec_out, pps_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [37:0] want_ns [4];
        logic        want_busy [4];
        want_ns[0] = 38'h100;  want_busy[0] = 1'b1;
        want_ns[1] = 38'hA00;  want_busy[1] = 1'b1;
        want_ns[2] = 38'h1300; want_busy[2] = 1'b0;
        want_ns[3] = 38'h1D00; want_busy[3] = 1'b0;
        period_adj_in = 40'h0900000000;
        time_ld_in = 1'b1; time_reg_ns_in = 38'h100; time_reg_sec_in = 48'd7;
        adj_ld_in = 1'b1; adj_ld_data_in = 32'd2;
        period_ld_in = 1'b1; period_in = 40'h0A00000000; time_acc_modulo_in = 38'h3B9ACA0000;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if ({time_reg_ns_out, time_reg_sec_out, adj_busy_out} !== {want_ns[i], 48'd7, want_busy[i]}) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got ns=%h sec=%h busy=%b want ns=%h sec=7 busy=%b",
                         i, time_reg_ns_out, time_reg_sec_out, adj_busy_out, want_ns[i], want_busy[i]);
            end
        end
        period_ld_in = 1'b1; period_in = 40'h0800000000;
        step();
    endtask

    task automatic test_random();
        logic [29:0] mod_ns;
        period_ld_in = 1'b1; period_in = 40'h0800000000;
        time_acc_modulo_in = {30'd200, 8'd0};
        time_ld_in = 1'b1; time_reg_ns_in = 38'd0; time_reg_sec_in = 48'd0;
        step();
        for (int c = 0; c < 800; c++) begin
            period_adj_in = {8'($urandom_range(15, 1)), 32'($urandom)};
            rtc_rst_in    = ($urandom_range(63, 0) == 0);
            time_ld_in    = ($urandom_range(15, 0) == 0);
            period_ld_in  = ($urandom_range(31, 0) == 0);
            adj_ld_in     = ($urandom_range(11, 0) == 0);
            time_reg_ns_in  = 38'($urandom_range(32'h27FF, 0));
            time_reg_sec_in = {16'($urandom), 32'($urandom)};
            adj_ld_data_in  = 32'($urandom_range(12, 0));
            period_in       = {8'($urandom_range(15, 1)), 32'($urandom)};
            mod_ns          = 30'($urandom_range(400, 40));
            time_acc_modulo_in = {mod_ns, 8'($urandom)};
            step();
            n_checks++;
            if ({time_reg_ns_out, time_reg_sec_out, adj_busy_out, pps_out} !==
                {m_acc[61:24], m_sec, (m_adj != 32'd0), m_pps}) begin
                n_fail++;
                $display("FAIL random[%0d]: got ns=%h sec=%h busy=%b pps=%b want ns=%h sec=%h busy=%b pps=%b",
                         c, time_reg_ns_out, time_reg_sec_out, adj_busy_out, pps_out,
                         m_acc[61:24], m_sec, (m_adj != 32'd0), m_pps);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        rtc_rst_in = 1'b0; time_ld_in = 1'b0; period_ld_in = 1'b0; adj_ld_in = 1'b0;
        time_reg_ns_in = 38'd0; time_reg_sec_in = 48'd0;
        period_in = 40'h0800000000; time_acc_modulo_in = 38'h3B9ACA0000;
        adj_ld_data_in = 32'd0; period_adj_in = 40'h0900000000;
        m_acc = 62'd0; m_sec = 48'd0; m_adj = 32'd0; m_pps = 1'b0;
        m_per = 40'h0800000000; m_mod = 38'h3B9ACA0000;

        test_reset();
        test_period();
        test_rollover();
        test_adjust();
        test_rtc_rst();
        test_sec_wrap();
        test_load_above_modulo();
        test_back_to_back();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
